// File: rtl/bf_pkg.sv
// Shared opcode bytes and FSM state encoding for the bfX execute stage.
package bf_pkg;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_LOOP  = 8'h5B;
    localparam logic [7:0] OP_END   = 8'h5D;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_HALT  = 8'h00;

    typedef enum logic [2:0] {
        ST_LD_A,
        ST_LD_D,
        ST_EXEC,
        ST_SKIP,
        ST_OUT,
        ST_IN,
        ST_HALT,
        ST_ERR
    } state_e;

endpackage

// File: rtl/addersub_16.sv
// 16-bit adder/subtractor used for the data pointer and the PC; wraps modulo 65536.
module addersub_16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        sub_i,
    output logic [15:0] y_o
);

    assign y_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/addersub_8.sv
// 8-bit adder/subtractor used for the current cell; wraps modulo 256.
module addersub_8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       sub_i,
    output logic [7:0] y_o
);

    assign y_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/bf_loop_stack.sv
// LIFO of loop return PCs; the caller never pushes when full nor pops when empty.
module bf_loop_stack #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] count_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] push_idx;
    logic [AW-1:0] top_idx;

    // The slot above the top doubles as the push address.
    assign push_idx = count_q[AW-1:0];
    assign top_idx  = push_idx - AW'(1);
    assign top_o    = mem_q[top_idx];
    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (push_i && !full_o) begin
            mem_q[push_idx] <= data_i;
            count_q         <= count_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/bf_exec.sv
// Execute stage of the bfX core: one opcode per handshake, cached cell with write-through,
// loop stack, forward skip over zero-cell loops and byte I/O handshakes.
module bf_exec
    import bf_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int SKIP_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] pc_o,
    input  logic        instr_valid_i,
    input  logic [7:0]  instr_i,
    output logic        instr_ready_o,
    output logic [15:0] dmem_addr_o,
    input  logic [7:0]  dmem_rdata_i,
    output logic        dmem_we_o,
    output logic [7:0]  dmem_wdata_o,
    output logic        out_valid_o,
    output logic [7:0]  out_data_o,
    input  logic        out_ready_i,
    output logic        in_ready_o,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        halted_o,
    output logic        error_o
);

    state_e            state_q, state_d;
    logic [15:0]       pc_q, pc_d;
    logic [15:0]       dp_q, dp_d;
    logic [7:0]        cell_q, cell_d;
    logic [SKIP_W-1:0] depth_q, depth_d;
    logic              we_q, we_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              instr_ready_q, out_valid_q, in_ready_q, halted_q, error_q;

    logic [7:0]  cell_sum;
    logic [15:0] dp_sum, pc_inc, stk_top;
    logic        stk_push, stk_pop, stk_full, stk_empty, cell_zero;

    assign cell_zero = (cell_q == 8'h00);

    addersub_8  u_cell_add (.a_i(cell_q), .b_i(8'd1),  .sub_i(instr_i == OP_DEC),  .y_o(cell_sum));
    addersub_16 u_dp_add   (.a_i(dp_q),   .b_i(16'd1), .sub_i(instr_i == OP_LEFT), .y_o(dp_sum));
    addersub_16 u_pc_add   (.a_i(pc_q),   .b_i(16'd1), .sub_i(1'b0),               .y_o(pc_inc));

    bf_loop_stack #(.DEPTH(STACK_DEPTH), .W(16)) u_stack (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        dp_d     = dp_q;
        cell_d   = cell_q;
        depth_d  = depth_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        case (state_q)
            ST_LD_A: state_d = ST_LD_D;
            ST_LD_D: begin
                cell_d  = dmem_rdata_i;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (instr_valid_i) begin
                    case (instr_i)
                        OP_INC, OP_DEC: begin
                            cell_d  = cell_sum;
                            we_d    = 1'b1;
                            wdata_d = cell_sum;
                            pc_d    = pc_inc;
                        end
                        OP_RIGHT, OP_LEFT: begin
                            dp_d    = dp_sum;
                            pc_d    = pc_inc;
                            state_d = ST_LD_A;
                        end
                        OP_OUT: begin
                            pc_d    = pc_inc;
                            state_d = ST_OUT;
                        end
                        OP_IN: begin
                            pc_d    = pc_inc;
                            state_d = ST_IN;
                        end
                        OP_LOOP: begin
                            if (cell_zero) begin
                                depth_d = SKIP_W'(1);
                                pc_d    = pc_inc;
                                state_d = ST_SKIP;
                            end else if (stk_full) begin
                                state_d = ST_ERR;
                            end else begin
                                stk_push = 1'b1;
                                pc_d     = pc_inc;
                            end
                        end
                        OP_END: begin
                            // A non-zero cell jumps back but leaves the entry for the next pass.
                            if (stk_empty) begin
                                state_d = ST_ERR;
                            end else if (!cell_zero) begin
                                pc_d = stk_top;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = pc_inc;
                            end
                        end
                        OP_HALT: state_d = ST_HALT;
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            ST_SKIP: begin
                if (instr_valid_i) begin
                    pc_d = pc_inc;
                    case (instr_i)
                        OP_LOOP: begin
                            if (depth_q == '1) state_d = ST_ERR;
                            else               depth_d = depth_q + SKIP_W'(1);
                        end
                        OP_END: begin
                            depth_d = depth_q - SKIP_W'(1);
                            if (depth_q == SKIP_W'(1)) state_d = ST_EXEC;
                        end
                        OP_HALT: state_d = ST_HALT;
                        default: ;
                    endcase
                end
            end
            ST_OUT: begin
                if (out_ready_i) state_d = ST_EXEC;
            end
            ST_IN: begin
                if (in_valid_i) begin
                    cell_d  = in_data_i;
                    we_d    = 1'b1;
                    wdata_d = in_data_i;
                    state_d = ST_EXEC;
                end
            end
            default: ;
        endcase
    end

    // Handshake/status outputs are registered decodes of the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_LD_A;
            pc_q          <= '0;
            dp_q          <= '0;
            cell_q        <= '0;
            depth_q       <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            instr_ready_q <= 1'b0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            halted_q      <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            dp_q          <= dp_d;
            cell_q        <= cell_d;
            depth_q       <= depth_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            instr_ready_q <= (state_d == ST_EXEC) || (state_d == ST_SKIP);
            out_valid_q   <= (state_d == ST_OUT);
            in_ready_q    <= (state_d == ST_IN);
            halted_q      <= (state_d == ST_HALT);
            error_q       <= (state_d == ST_ERR);
        end
    end

    assign pc_o          = pc_q;
    assign instr_ready_o = instr_ready_q;
    assign dmem_addr_o   = dp_q;
    assign dmem_we_o     = we_q;
    assign dmem_wdata_o  = wdata_q;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = cell_q;
    assign in_ready_o    = in_ready_q;
    assign halted_o      = halted_q;
    assign error_o       = error_q;

endmodule
